// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file writeback path.
// Used by the writeback arbiter and its round-robin sub-arbiter.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // "reg" is a keyword, so the destination field is named idx.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] idx;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter: bit 0 is the ALU side, bit 1 the MEM side.
// On a tie the side not granted most recently wins; the pointer moves only on advance.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    src_e last_q;
    src_e last_d;

    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || last_q == SRC_MEM)) begin
            grant[0] = 1'b1;
        end else if (req[1]) begin
            grant[1] = 1'b1;
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance && grant[1]) begin
            last_d = SRC_MEM;
        end else if (advance && grant[0]) begin
            last_d = SRC_ALU;
        end
    end

    // Reset to MEM so the ALU wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= SRC_MEM;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port plus the pending-write
// scoreboard that decode uses to stall on read-after-write hazards.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [ADDR_W-1:0]    mem_reg,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 mem_ready,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_reg,
    input  logic                 flush,
    output logic [2**ADDR_W-1:0] busy_mask,
    output logic                 RegWre,
    output logic [ADDR_W-1:0]    WriteReg,
    output logic [DATA_W-1:0]    WriteData
);

    localparam int NREG = 2**ADDR_W;

    logic [1:0]        grant;
    logic              xfer;
    src_e              sel_src;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic              we_q,    we_d;
    logic [ADDR_W-1:0] wreg_q,  wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]   busy_q,  busy_d;

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst_n   (RST),
        .req     ({mem_valid, alu_valid}),
        .advance (xfer),
        .grant   (grant)
    );

    assign alu_ready = RST & grant[0];
    assign mem_ready = RST & grant[1];
    assign xfer      = alu_ready | mem_ready;

    assign sel_src  = grant[1] ? SRC_MEM : SRC_ALU;
    assign sel_reg  = (sel_src == SRC_MEM) ? mem_reg  : alu_reg;
    assign sel_data = (sel_src == SRC_MEM) ? mem_data : alu_data;

    // Writes to r0 still consume the grant but never reach the register file.
    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (xfer && sel_reg != '0) begin
            we_d    = 1'b1;
            wreg_d  = sel_reg;
            wdata_d = sel_data;
        end
    end

    // Per-register busy bit: flush beats issue, and issue beats the clearing write.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_bit
                assign busy_d[gi] = !flush &&
                    ((issue_valid && issue_reg == ADDR_W'(gi)) ||
                     (busy_q[gi] && !(we_q && wreg_q == ADDR_W'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign RegWre    = we_q;
    assign WriteReg  = wreg_q;
    assign WriteData = wdata_q;
    assign busy_mask = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of grants, writes and busy bits.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          alu_valid, mem_valid, issue_valid, flush;
    logic [AW-1:0] alu_reg, mem_reg, issue_reg;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic [NR-1:0] busy_mask;
    logic          RegWre;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit            m_last_mem;
    bit            m_busy[NR];
    bit            m_we;
    logic [AW-1:0] m_wreg;
    logic [DW-1:0] m_wdata;
    bit            e_alu, e_mem;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .alu_valid   (alu_valid),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .flush       (flush),
        .busy_mask   (busy_mask),
        .RegWre      (RegWre),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData)
    );

    always #5 CLK = ~CLK;

    function automatic logic [NR-1:0] model_mask();
        logic [NR-1:0] m;
        m = '0;
        for (int i = 0; i < NR; i++) m[i] = m_busy[i];
        return m;
    endfunction

    // Apply inputs and predict which source is accepted this cycle.
    task automatic drive(input bit rst, input bit av, input int ar, input logic [DW-1:0] ad,
                         input bit mv, input int mr, input logic [DW-1:0] md,
                         input bit iv, input int ir, input bit fl);
        RST = rst; alu_valid = av; alu_reg = ar[AW-1:0]; alu_data = ad;
        mem_valid = mv; mem_reg = mr[AW-1:0]; mem_data = md;
        issue_valid = iv; issue_reg = ir[AW-1:0]; flush = fl;
        e_alu = 1'b0;
        e_mem = 1'b0;
        if (rst) begin
            if (av && (!mv || m_last_mem)) e_alu = 1'b1;
            else if (mv) e_mem = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Clock edge: advance the model exactly as the rules describe.
    task automatic tick();
        @(posedge CLK);
        if (!RST) begin
            m_last_mem = 1'b1;
            m_we = 1'b0; m_wreg = '0; m_wdata = '0;
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else begin
            if (m_we) m_busy[m_wreg] = 1'b0;
            if (issue_valid && issue_reg != 0) m_busy[issue_reg] = 1'b1;
            if (flush) for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
            m_we = 1'b0;
            if (e_alu) begin
                m_last_mem = 1'b0;
                if (alu_reg != 0) begin m_we = 1'b1; m_wreg = alu_reg; m_wdata = alu_data; end
            end else if (e_mem) begin
                m_last_mem = 1'b1;
                if (mem_reg != 0) begin m_we = 1'b1; m_wreg = mem_reg; m_wdata = mem_data; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 1, 3, 32'h11, 1, 4, 32'h22, 1, 6, 0);
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b expected 0", alu_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b expected 0", mem_ready); end
        tick();
        checks++; if (RegWre !== 1'b0) begin errors++; $display("FAIL reset_regwre: got %b expected 0", RegWre); end
        checks++; if (WriteReg !== '0) begin errors++; $display("FAIL reset_writereg: got %0d expected 0", WriteReg); end
        checks++; if (WriteData !== '0) begin errors++; $display("FAIL reset_writedata: got %h expected 0", WriteData); end
        checks++; if (busy_mask !== '0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_mask); end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 3, 32'hA000_0000 + i, 1, 4, 32'hB000_0000 + i, 0, 0, 0);
            checks++; if (alu_ready !== (i % 2 == 0)) begin errors++; $display("FAIL contention_alu_ready[%0d]: got %b expected %b", i, alu_ready, (i % 2 == 0)); end
            checks++; if (mem_ready !== (i % 2 == 1)) begin errors++; $display("FAIL contention_mem_ready[%0d]: got %b expected %b", i, mem_ready, (i % 2 == 1)); end
            tick();
            checks++; if (RegWre !== 1'b1) begin errors++; $display("FAIL contention_regwre[%0d]: got %b expected 1", i, RegWre); end
            checks++; if (WriteReg !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin errors++; $display("FAIL contention_writereg[%0d]: got %0d expected %0d", i, WriteReg, (i % 2 == 0) ? 3 : 4); end
        end
        idle(); tick();
    endtask

    task automatic test_alu_only();
        drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_only_ready: got %b expected 1", alu_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL alu_only_mem_ready: got %b expected 0", mem_ready); end
        tick();
        idle();
        checks++; if (RegWre !== 1'b1) begin errors++; $display("FAIL alu_only_regwre: got %b expected 1", RegWre); end
        checks++; if (WriteReg !== 5'd5) begin errors++; $display("FAIL alu_only_writereg: got %0d expected 5", WriteReg); end
        checks++; if (WriteData !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_only_writedata: got %h expected deadbeef", WriteData); end
        tick();
        checks++; if (RegWre !== 1'b0) begin errors++; $display("FAIL alu_only_regwre_after: got %b expected 0", RegWre); end
        checks++; if (WriteData !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_only_hold: got %h expected deadbeef", WriteData); end
    endtask

    task automatic test_reg0();
        drive(1, 0, 0, 0, 1, 0, 32'h1234, 1, 0, 0);
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reg0_ready: got %b expected 1", mem_ready); end
        tick();
        idle();
        checks++; if (RegWre !== 1'b0) begin errors++; $display("FAIL reg0_regwre: got %b expected 0", RegWre); end
        checks++; if (busy_mask !== model_mask()) begin errors++; $display("FAIL reg0_busy: got %h expected %h", busy_mask, model_mask()); end
        tick();
    endtask

    task automatic test_scoreboard();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) drive(1, 1, 7, 32'h0707, 0, 0, 0, 0, 0, 0);
            else idle();
            checks++; if (busy_mask[7] !== 1'b1) begin errors++; $display("FAIL sb_pending[%0d]: got %b expected 1", i, busy_mask[7]); end
            tick();
        end
        idle();
        checks++; if (RegWre !== 1'b1 || busy_mask[7] !== 1'b1) begin errors++; $display("FAIL sb_write_cycle: got regwre=%b busy7=%b expected 1 1", RegWre, busy_mask[7]); end
        tick();
        checks++; if (busy_mask[7] !== 1'b0) begin errors++; $display("FAIL sb_cleared: got %b expected 0", busy_mask[7]); end
        // Re-issue r7 on the same edge that retires its previous write.
        drive(1, 0, 0, 0, 0, 0, 0, 1, 7, 0); tick();
        drive(1, 1, 7, 32'h7777, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        checks++; if (RegWre !== 1'b1) begin errors++; $display("FAIL sb_reissue_regwre: got %b expected 1", RegWre); end
        tick();
        idle();
        checks++; if (busy_mask[7] !== 1'b1) begin errors++; $display("FAIL sb_reissue_busy: got %b expected 1", busy_mask[7]); end
        tick();
        checks++; if (busy_mask !== 32'h0000_0080) begin errors++; $display("FAIL sb_reissue_mask: got %h expected 00000080", busy_mask); end
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 2, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 9, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 31, 0); tick();
        checks++; if (busy_mask !== 32'h8000_0204) begin errors++; $display("FAIL flush_setup: got %h expected 80000204", busy_mask); end
        drive(1, 1, 12, 32'hA5A5_5A5A, 0, 0, 0, 1, 9, 1);
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", alu_ready); end
        tick();
        idle();
        checks++; if (busy_mask !== '0) begin errors++; $display("FAIL flush_busy: got %h expected 0", busy_mask); end
        checks++; if (RegWre !== 1'b1 || WriteReg !== 5'd12) begin errors++; $display("FAIL flush_inflight: got regwre=%b reg=%0d expected 1 12", RegWre, WriteReg); end
        tick();
    endtask

    task automatic test_random();
        bit av = 0, mv = 0, iv, fl;
        int ar = 0, mr = 0, ir;
        logic [DW-1:0] ad = '0, md = '0;
        for (int c = 0; c < 400; c++) begin
            if (!av) begin av = ($urandom_range(0, 3) != 0); ar = $urandom_range(0, NR - 1); ad = $urandom; end
            if (!mv) begin mv = ($urandom_range(0, 3) != 0); mr = $urandom_range(0, NR - 1); md = $urandom; end
            iv = ($urandom_range(0, 2) == 0);
            ir = $urandom_range(0, NR - 1);
            fl = ($urandom_range(0, 19) == 0);
            drive(1, av, ar, ad, mv, mr, md, iv, ir, fl);
            checks++; if (alu_ready !== e_alu || mem_ready !== e_mem) begin errors++; $display("FAIL rand_ready[%0d]: got alu=%b mem=%b expected alu=%b mem=%b", c, alu_ready, mem_ready, e_alu, e_mem); end
            tick();
            checks++; if (RegWre !== m_we) begin errors++; $display("FAIL rand_regwre[%0d]: got %b expected %b", c, RegWre, m_we); end
            checks++; if (WriteReg !== m_wreg || WriteData !== m_wdata) begin errors++; $display("FAIL rand_wb[%0d]: got %0d/%h expected %0d/%h", c, WriteReg, WriteData, m_wreg, m_wdata); end
            checks++; if (busy_mask !== model_mask()) begin errors++; $display("FAIL rand_busy[%0d]: got %h expected %h", c, busy_mask, model_mask()); end
            if (e_alu) av = 0;
            if (e_mem) mv = 0;
        end
        idle(); tick();
    endtask

    task automatic test_midreset();
        drive(1, 1, 10, 32'h1010, 1, 11, 32'h1111, 1, 20, 0);
        tick();
        drive(0, 1, 10, 32'h1010, 1, 11, 32'h1111, 0, 0, 0);
        checks++; if (RegWre !== 1'b1) begin errors++; $display("FAIL midrst_pending: got %b expected 1", RegWre); end
        checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got alu=%b mem=%b expected 0 0", alu_ready, mem_ready); end
        tick();
        checks++; if (RegWre !== 1'b0) begin errors++; $display("FAIL midrst_regwre: got %b expected 0", RegWre); end
        checks++; if (busy_mask !== '0) begin errors++; $display("FAIL midrst_busy: got %h expected 0", busy_mask); end
        drive(1, 1, 10, 32'h1010, 1, 11, 32'h1111, 0, 0, 0);
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL midrst_tie: got alu=%b mem=%b expected 1 0", alu_ready, mem_ready); end
        tick();
        idle();
        checks++; if (RegWre !== 1'b1 || WriteReg !== 5'd10) begin errors++; $display("FAIL midrst_resume: got regwre=%b reg=%0d expected 1 10", RegWre, WriteReg); end
        tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_alu_only();
        test_reg0();
        test_scoreboard();
        test_flush();
        test_random();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
